// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage -- two-state (FETCH / EXEC) instruction fetch unit.
//
// Each instruction is fetched from instruction memory in FETCH, then held in
// EXEC until downstream releases it. On that release the next PC is chosen:
// jump target, taken branch, or sequential.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   imem_req/imem_addr    read request; imem_addr is always the current pc
//   imem_ready/imem_rdata read data strobe and word (only looked at while
//                         imem_req is high)
//   instr, op, funct      registered instruction and its decoder fields
//   instr_valid           instr is being executed this cycle (EXEC)
//   pc, pc_plus4          address of instr and that address + 4
//   stall                 downstream holds the current instruction
//   branch, zero, jump    next-PC controls, used only when EXEC retires
//   instr_count           retired-instruction count
//
// Optional feature: define FETCH_INSTR_CNT_EN to build the instruction
// counter; without it instr_count is tied to zero and no register exists.
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        stall,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic [31:0] instr_count
);

  // Word-align the reset vector so pc[1:0] is zero from the start.
  localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

  typedef enum logic {FETCH, EXEC} state_t;

  state_t      state, state_nxt;
  logic        armed;       // low from reset until the first edge after release
  logic        fetch_done;  // FETCH accepted a word this cycle
  logic        retire;      // EXEC releases the instruction this cycle
  logic [31:0] pc_q, instr_q, next_pc, br_off;

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  // Keeps imem_req low until one rising edge has passed with reset released,
  // so nothing is requested (or accepted) in the reset-release cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  // ---------------- next state / outputs ----------------
  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    fetch_done  = 1'b0;
    retire      = 1'b0;
    case (state)
      FETCH: begin
        imem_req   = armed;
        fetch_done = armed & imem_ready;
        if (fetch_done) state_nxt = EXEC;
      end
      EXEC: begin
        instr_valid = 1'b1;
        retire      = ~stall;
        if (retire) state_nxt = FETCH;
      end
    endcase
  end

  // ---------------- next PC ----------------
  assign pc_plus4 = pc_q + 32'd4;
  assign br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // jump is tested first so an unknown branch flag cannot disturb a jump.
  always_comb begin
    next_pc = pc_plus4;
    if (jump)                 next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    else if (branch && zero)  next_pc = pc_plus4 + br_off;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      pc_q <= RESET_PC_W;
    else if (retire) pc_q <= next_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          instr_q <= 32'h0;
    else if (fetch_done) instr_q <= imem_rdata;
  end

`ifdef FETCH_INSTR_CNT_EN
  logic [31:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt_q <= 32'h0;
    else if (retire) cnt_q <= cnt_q + 32'd1;
  end
  assign instr_count = cnt_q;
`else
  assign instr_count = 32'h0;
`endif

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign op        = instr_q[31:26];
  assign funct     = instr_q[5:0];

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage -- self-checking bench for fetch_stage.
// A table of instructions (memory word, next-PC controls, wait/stall cycles,
// expected next fetch address) is run in order; expected fetch addresses go
// through a queue and are checked when the DUT issues its next request.
// Hand-written sequences cover reset mid-fetch and a high-region jump on a
// second instance with an unaligned RESET_PC.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk, rst_n;
  logic        imem_req, imem_ready, instr_valid, stall, branch, zero, jump;
  logic [31:0] imem_addr, imem_rdata, instr, pc, pc_plus4, instr_count;
  logic [5:0]  op, funct;

  logic        h_rst_n, h_req, h_ready, h_valid, h_stall, h_branch, h_zero, h_jump;
  logic [31:0] h_addr, h_rdata, h_instr, h_pc, h_pc_plus4, h_count;
  logic [5:0]  h_op, h_funct;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr), .op(op),
    .funct(funct), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .stall(stall), .branch(branch), .zero(zero), .jump(jump),
    .instr_count(instr_count)
  );

  fetch_stage #(.RESET_PC(32'h4000_0003)) dut_hi (
    .clk(clk), .rst_n(h_rst_n), .imem_req(h_req), .imem_addr(h_addr),
    .imem_ready(h_ready), .imem_rdata(h_rdata), .instr(h_instr), .op(h_op),
    .funct(h_funct), .instr_valid(h_valid), .pc(h_pc), .pc_plus4(h_pc_plus4),
    .stall(h_stall), .branch(h_branch), .zero(h_zero), .jump(h_jump),
    .instr_count(h_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        br, z, j;
    int          wait_c, stall_c;
    logic [31:0] nxt;
  } vec_t;

  vec_t        tbl [11];
  logic [31:0] addr_q [$];
  logic [31:0] exp_addr, exp_cnt;
  int          n_tests, n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entered at a falling edge with the DUT in FETCH; leaves at the falling
  // edge where the DUT is back in FETCH for the following instruction.
  task automatic run_row(input vec_t r);
    exp_addr = addr_q.pop_front();
    chk("fetch_req", 32'(imem_req), 32'd1);
    chk("fetch_addr", imem_addr, exp_addr);
    chk("fetch_valid", 32'(instr_valid), 32'd0);
    imem_ready = 1'b0;
    for (int w = 0; w < r.wait_c; w++) begin
      imem_rdata = $urandom;
      branch = 1'b1; zero = 1'b1; jump = 1'b1;
      @(negedge clk);
      chk("wait_addr", imem_addr, exp_addr);
      chk("wait_pc", pc, exp_addr);
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_valid", 32'(instr_valid), 32'd0);
    end
    branch = 1'b0; zero = 1'b0; jump = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = r.rdata;
    @(negedge clk);
    chk("exec_valid", 32'(instr_valid), 32'd1);
    chk("exec_req", 32'(imem_req), 32'd0);
    chk("exec_instr", instr, r.rdata);
    chk("exec_op", 32'(op), 32'(r.rdata[31:26]));
    chk("exec_funct", 32'(funct), 32'(r.rdata[5:0]));
    chk("exec_pc", pc, exp_addr);
    chk("exec_pc4", pc_plus4, exp_addr + 32'd4);
    chk("exec_cnt", instr_count, exp_cnt);
    // Memory side is ignored in EXEC; drive junk on it.
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    for (int s = 0; s < r.stall_c; s++) begin
      stall = 1'b1; branch = 1'b1; zero = 1'b1; jump = 1'b1;
      @(negedge clk);
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_instr", instr, r.rdata);
      chk("stall_pc", pc, exp_addr);
      chk("stall_cnt", instr_count, exp_cnt);
    end
    stall = 1'b0; branch = r.br; zero = r.z; jump = r.j;
    addr_q.push_back(r.nxt);
    @(negedge clk);
    branch = 1'b0; zero = 1'b0; jump = 1'b0;
`ifdef FETCH_INSTR_CNT_EN
    exp_cnt = exp_cnt + 32'd1;
`endif
    chk("retire_cnt", instr_count, exp_cnt);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; exp_cnt = 32'h0;
    //          rdata         br    z     j     wait stall next
    tbl[0]  = '{32'h2008_0005, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0000_0004};
    tbl[1]  = '{32'h2008_0005, 1'b0, 1'b0, 1'b0, 5, 3, 32'h0000_0008};
    tbl[2]  = '{32'h2008_0005, 1'b0, 1'b0, 1'b0, 1, 0, 32'h0000_000C};
    tbl[3]  = '{32'h2008_0005, 1'b0, 1'b0, 1'b0, 0, 1, 32'h0000_0010};
    tbl[4]  = '{32'h1000_0003, 1'b1, 1'b0, 1'b0, 0, 0, 32'h0000_0014};
    tbl[5]  = '{32'h0800_0004, 1'b0, 1'b0, 1'b1, 0, 0, 32'h0000_0010};
    tbl[6]  = '{32'h1000_0003, 1'b1, 1'b1, 1'b0, 0, 0, 32'h0000_0020};
    tbl[7]  = '{32'h1000_FFF6, 1'b1, 1'b1, 1'b0, 0, 0, 32'hFFFF_FFFC};
    tbl[8]  = '{32'h2008_0005, 1'b0, 1'b0, 1'b0, 2, 2, 32'h0000_0000};
    tbl[9]  = '{32'h0800_0010, 1'b1, 1'b1, 1'b1, 0, 0, 32'h0000_0040};
    tbl[10] = '{32'h2008_0005, 1'b1, 1'b0, 1'b0, 0, 0, 32'h0000_0044};

    rst_n = 1'b0; h_rst_n = 1'b0;
    imem_ready = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
    branch = 1'b0; zero = 1'b0; jump = 1'b0;
    h_ready = 1'b0; h_rdata = 32'h0; h_stall = 1'b0;
    h_branch = 1'b0; h_zero = 1'b0; h_jump = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_cnt", instr_count, 32'h0);
    rst_n = 1'b1; h_rst_n = 1'b1;
    #1 chk("rel_req_low", 32'(imem_req), 32'd0);
    @(negedge clk);
    addr_q.push_back(32'h0);

    for (int i = 0; i < 2; i++) run_row(tbl[i]);

    // Reset asserted mid-FETCH at pc 8; ready during reset must be ignored.
    chk("mid_addr", imem_addr, addr_q[0]);
    void'(addr_q.pop_front());
    imem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_pc", pc, 32'h0);
    chk("arst_valid", 32'(instr_valid), 32'd0);
    chk("arst_cnt", instr_count, 32'h0);
    imem_ready = 1'b1;
    imem_rdata = 32'h1234_5678;
    @(negedge clk);
    @(negedge clk);
    chk("arst_instr", instr, 32'h0);
    chk("arst_req2", 32'(imem_req), 32'd0);
    rst_n = 1'b1;
    #1 chk("arel_req_low", 32'(imem_req), 32'd0);
    @(negedge clk);
    chk("arel_instr", instr, 32'h0);
    chk("arel_valid", 32'(instr_valid), 32'd0);
    exp_cnt = 32'h0;
    addr_q.push_back(32'h0);

    for (int i = 0; i < 11; i++) run_row(tbl[i]);

    // Second instance: unaligned reset vector, jump with unknown branch.
    chk("hi_req", 32'(h_req), 32'd1);
    chk("hi_addr", h_addr, 32'h4000_0000);
    h_ready = 1'b1;
    h_rdata = 32'h0800_0010;
    @(negedge clk);
    h_ready = 1'b0;
    chk("hi_valid", 32'(h_valid), 32'd1);
    chk("hi_instr", h_instr, 32'h0800_0010);
    chk("hi_op", 32'(h_op), 32'h2);
    chk("hi_funct", 32'(h_funct), 32'h10);
    chk("hi_pc", h_pc, 32'h4000_0000);
    chk("hi_pc4", h_pc_plus4, 32'h4000_0004);
    h_jump = 1'b1; h_branch = 1'bx; h_zero = 1'b1;
    @(negedge clk);
    h_jump = 1'b0; h_branch = 1'b0; h_zero = 1'b0;
    chk("hi_jaddr", h_addr, 32'h4000_0040);
    chk("hi_jreq", 32'(h_req), 32'd1);
`ifdef FETCH_INSTR_CNT_EN
    chk("hi_cnt", h_count, 32'd1);
`else
    chk("hi_cnt", h_count, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
